mc_controller_fsm: RTL

MC_CONTROLLER_FSM -- requirements
Module: mc_controller_fsm

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mem_watchdog.sv | 28 ++
 rtl/mc_controller_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operations, mux selects, trap causes and the per-state control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_WB_ALU,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_TRAP
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_JUMP  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [2:0] SRCB_REG  = 3'd0;
  localparam logic [2:0] SRCB_ONE  = 3'd1;
  localparam logic [2:0] SRCB_IMM  = 3'd2;
  localparam logic [2:0] SRCB_JOFF = 3'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic       reg_write;
    logic       reg_write_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       pc_beq_cond;
    logic       pc_bne_cond;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
  } ctrl_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive cycles a memory access has been waiting; expired flags
// that the wait has reached the configured limit.
module mem_watchdog
  import mc_pkg::*;
#(
  parameter int TMO_W   = 4,
  parameter int MEM_TMO = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TMO_W'(MEM_TMO));

endmodule

// File: rtl/mc_controller_fsm.sv
// Multi-cycle CPU control unit: Moore sequencer with memory-wait watchdog,
// trap reporting and a retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction, PC+1, wait for mem_ready
// DECODE   | branch target add, dispatch on opcode
// EXEC_R   | register-register ALU op from funcfield
// EXEC_I   | register + immediate add
// MEM_ADDR | effective address add
// MEM_RD   | load access, wait for mem_ready
// MEM_WB   | load data to register file
// MEM_WR   | store access, wait for mem_ready
// WB_ALU   | ALU result to register file
// BRANCH   | compare by subtract, conditional PC update
// JUMP     | unconditional PC update
// HALT     | absorbing, halted=1
// TRAP     | absorbing, trap=1 with trap_cause
module mc_controller_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNC_W   = 4,
  parameter int ALUOP_W  = 3,
  parameter int TMO_W    = 4,
  parameter int MEM_TMO  = 12,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   funcfield,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          pc_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src_a,
  output logic [2:0]          alu_src_b,
  output logic                reg_write,
  output logic                reg_write_dst,
  output logic                mem_to_reg,
  output logic                pc_write,
  output logic                pc_beq_cond,
  output logic                pc_bne_cond,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                halted,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired
);

  state_t             state, state_nxt;
  ctrl_t              ctrl;
  logic [ALUOP_W-1:0] alu_op_c;
  logic [3:0]         op_in, op_q;
  logic [1:0]         cause_set;
  logic               in_wait, retire, expired;
  logic               unused_in;

  assign op_in     = 4'(opcode);
  // zero only feeds the datapath PC-enable logic; upper func bits are not ALU ops
  assign unused_in = ^{zero, funcfield};

  mem_watchdog #(.TMO_W(TMO_W), .MEM_TMO(MEM_TMO)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!(in_wait && !mem_ready)),
    .waiting (in_wait && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    ctrl      = '0;
    alu_op_c  = ALUOP_W'(ALU_ADD);
    state_nxt = state;
    in_wait   = 1'b0;
    retire    = 1'b0;
    cause_set = TC_NONE;
    case (state)
      S_FETCH: begin
        in_wait        = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end else if (expired) begin
          state_nxt = S_TRAP;
          cause_set = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM;
        case (op_in)
          OP_RTYPE:      state_nxt = S_EXEC_R;
          OP_ADDI:       state_nxt = S_EXEC_I;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_JUMP:       state_nxt = S_JUMP;
          OP_HALT:       state_nxt = S_HALT;
          default: begin
            state_nxt = S_TRAP;
            cause_set = TC_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_op_c       = funcfield[ALUOP_W-1:0];
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        state_nxt      = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_nxt      = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_write_dst = (op_q == OP_RTYPE);
        retire             = 1'b1;
        state_nxt          = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_nxt      = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        in_wait        = 1'b1;
        ctrl.mem_read  = (state == S_MEM_RD);
        ctrl.mem_write = (state == S_MEM_WR);
        if (mem_ready) begin
          state_nxt = (state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
          retire    = (state == S_MEM_WR);
        end else if (expired) begin
          state_nxt = S_TRAP;
          cause_set = TC_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_c         = ALUOP_W'(ALU_SUB);
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.pc_src      = PCSRC_ALUOUT;
        ctrl.pc_beq_cond = (op_q == OP_BEQ);
        ctrl.pc_bne_cond = (op_q == OP_BNE);
        retire           = 1'b1;
        state_nxt        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_HALT, S_TRAP: begin
        alu_op_c = '0;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Opcode is captured at dispatch so later phases do not depend on IR timing
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      trap_cause <= TC_NONE;
      retired    <= '0;
    end else begin
      if (state == S_DECODE)    op_q       <= op_in;
      if (cause_set != TC_NONE) trap_cause <= cause_set;
      if (retire)               retired    <= retired + 1'b1;
    end
  end

  assign pc_src        = ctrl.pc_src;
  assign alu_op        = alu_op_c;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign reg_write     = ctrl.reg_write;
  assign reg_write_dst = ctrl.reg_write_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign pc_write      = ctrl.pc_write;
  assign pc_beq_cond   = ctrl.pc_beq_cond;
  assign pc_bne_cond   = ctrl.pc_bne_cond;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign halted        = (state == S_HALT);
  assign trap          = (state == S_TRAP);

endmodule
